// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the RV32M multiply/divide unit: funct3 codes,
// FSM state encodings and operand signedness helpers.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package muldiv_unit_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_FIX  = 2'b10,
    MD_DONE = 2'b11
  } md_state_e;

  // rs1 is treated as signed for every op except the fully unsigned ones
  function automatic logic md_a_signed(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is unsigned for MULHSU in addition to the unsigned ops
  function automatic logic md_b_signed(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_iter.sv
// One radix-2 step of the shared datapath. The accumulator is {hi, lo}.
// Multiply: lo holds the multiplier, hi the partial product; add operand
// into hi when lo[0] is set, then shift the whole thing right.
// Divide: lo holds the dividend/quotient, hi the partial remainder; shift
// left and keep the trial subtraction if it does not borrow.
module muldiv_iter #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] acc_i,
  input  logic [W-1:0]   opd_i,
  input  logic           div_i,
  output logic [2*W-1:0] acc_o
);

  logic [W:0]   sum;
  logic [2*W:0] shl;
  logic [W:0]   diff;

  // Single shift-add or shift-subtract step selected by div_i
  always_comb begin
    sum   = {1'b0, acc_i[2*W-1:W]} + {1'b0, opd_i};
    shl   = {acc_i, 1'b0};
    diff  = shl[2*W:W] - {1'b0, opd_i};
    acc_o = '0;
    if (div_i) begin
      // shifted remainder is below 2*divisor, so a clear bit W means no borrow
      if (!diff[W]) acc_o = {diff[W-1:0], shl[W-1:1], 1'b1};
      else          acc_o = shl[2*W-1:0];
    end else begin
      if (acc_i[0]) acc_o = {sum, acc_i[W-1:1]};
      else          acc_o = {1'b0, acc_i[2*W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready for a request; divide-by-zero/overflow resolved here
//   BUSY    | one shift-add / shift-subtract step per cycle, W steps
//   FIX     | restore result sign and pick the result half
//   DONE    | result held on rslt with out_valid until consumed
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WORD_WIDTH = `WORD_WIDTH,
  parameter int CNT_WIDTH  = $clog2(WORD_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] rslt
);

  localparam int W = WORD_WIDTH;
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  md_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
  logic [2:0]           op_q,    op_d;
  logic [2*W-1:0]       acc_q,   acc_d;
  logic [W-1:0]         opd_q,   opd_d;
  logic                 qneg_q,  qneg_d;
  logic                 rneg_q,  rneg_d;
  logic [W-1:0]         rslt_q,  rslt_d;

  logic [2*W-1:0] iter_acc;
  logic           a_neg, b_neg, b_zero, div_ovf;
  logic [W-1:0]   a_mag, b_mag;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix, rem_fix;

  muldiv_iter #(.W(W)) u_iter (
    .acc_i (acc_q),
    .opd_i (opd_q),
    .div_i (op_q[2]),
    .acc_o (iter_acc)
  );

  // Capture-time operand analysis and FIX-time sign restoration
  always_comb begin
    a_neg    = md_a_signed(op) & a[W-1];
    b_neg    = md_b_signed(op) & b[W-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    b_zero   = (b == '0);
    div_ovf  = ((op == MD_DIV) || (op == MD_REM)) && (a == SMIN) && (b == '1);
    prod_fix = qneg_q ? -acc_q : acc_q;
    quot_fix = qneg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_fix  = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opd_d   = opd_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    rslt_d  = rslt_q;
    if (flush) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (in_valid) begin
            op_d   = op;
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
            if (op[2]) begin
              acc_d = {{W{1'b0}}, a_mag};
              opd_d = b_mag;
            end else begin
              acc_d = {{W{1'b0}}, b_mag};
              opd_d = a_mag;
            end
            if (op[2] && b_zero) begin
              rslt_d  = op[1] ? a : '1;
              state_d = MD_DONE;
            end else if (div_ovf) begin
              rslt_d  = op[1] ? '0 : a;
              state_d = MD_DONE;
            end else begin
              cnt_d   = CNT_WIDTH'(W);
              state_d = MD_BUSY;
            end
          end
        end
        MD_BUSY: begin
          acc_d = iter_acc;
          cnt_d = cnt_q - CNT_WIDTH'(1);
          if (cnt_q <= CNT_WIDTH'(1)) state_d = MD_FIX;
        end
        MD_FIX: begin
          if (!op_q[2]) rslt_d = (op_q == MD_MUL) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
          else          rslt_d = op_q[1] ? rem_fix : quot_fix;
          state_d = MD_DONE;
        end
        MD_DONE: begin
          if (out_ready) state_d = MD_IDLE;
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      opd_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      rslt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      rslt_q  <= rslt_d;
    end
  end

  assign in_ready  = (state_q == MD_IDLE);
  assign out_valid = (state_q == MD_DONE);
  assign rslt      = rslt_q;

endmodule
